// File: rtl/pcf8563_sched.sv
// Command scheduler for the PCF8563 control module: one-time control-register
// init, periodic sec/min/hour polling, and serialised user time-set writes.
module pcf8563_sched #(
  parameter int         POLL_CYCLES = 50_000_000,
  parameter int         TIMEOUT     = 2_000_000,
  parameter logic [7:0] CTRL_INIT   = 8'h00
) (
  input  logic       CLOCK,
  input  logic       RST_n,
  output logic [7:0] oCall,
  input  logic       iDone,
  output logic [7:0] oWrData,
  input  logic [7:0] iRdData,
  input  logic       iSetReq,
  input  logic [7:0] iSetSec,
  input  logic [7:0] iSetMin,
  input  logic [7:0] iSetHour,
  output logic       oSetAck,
  output logic [7:0] oSec,
  output logic [7:0] oMin,
  output logic [7:0] oHour,
  output logic       oVL,
  output logic       oValid,
  output logic       oUpdate,
  output logic       oErr
);

  localparam int PW = $clog2(POLL_CYCLES);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [PW-1:0] POLL_RELOAD = PW'(POLL_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_CALL, S_GAP} state_t;
  typedef enum logic [1:0] {Q_INIT, Q_POLL, Q_SET} seq_t;

  state_t        state, state_d;
  seq_t          seq, seq_d;
  logic [1:0]    step, step_d;
  logic          cont, cont_d;
  logic [7:0]    call, call_d;
  logic [7:0]    wr_data, wr_data_d;
  logic [TW-1:0] tcnt, tcnt_d;
  logic [PW-1:0] pcnt, pcnt_d;
  logic          poll_pend, poll_pend_d;
  logic          set_pend, set_pend_d;
  logic [7:0]    lat_sec, lat_sec_d, lat_min, lat_min_d, lat_hour, lat_hour_d;
  logic [7:0]    w_min, w_min_d, w_hour, w_hour_d;
  logic [7:0]    sh_sec, sh_sec_d, sh_min, sh_min_d;
  logic          sh_vl, sh_vl_d;
  logic [7:0]    sec, sec_d, min, min_d, hour, hour_d;
  logic          vl, vl_d, valid, valid_d;
  logic          update, update_d, set_ack, set_ack_d, err, err_d;
  logic          expiry, poll_start, set_start;
  logic [7:0]    hour_rd;

  assign hour_rd = {2'b00, iRdData[5:0]};

  always_ff @(posedge CLOCK) begin
    if (!RST_n) begin
      state     <= S_INIT;
      seq       <= Q_INIT;
      step      <= 2'd0;
      cont      <= 1'b0;
      call      <= 8'h00;
      wr_data   <= 8'h00;
      tcnt      <= '0;
      pcnt      <= POLL_RELOAD;
      poll_pend <= 1'b0;
      set_pend  <= 1'b0;
      lat_sec   <= 8'h00;
      lat_min   <= 8'h00;
      lat_hour  <= 8'h00;
      w_min     <= 8'h00;
      w_hour    <= 8'h00;
      sh_sec    <= 8'h00;
      sh_min    <= 8'h00;
      sh_vl     <= 1'b0;
      sec       <= 8'h00;
      min       <= 8'h00;
      hour      <= 8'h00;
      vl        <= 1'b0;
      valid     <= 1'b0;
      update    <= 1'b0;
      set_ack   <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_d;
      seq       <= seq_d;
      step      <= step_d;
      cont      <= cont_d;
      call      <= call_d;
      wr_data   <= wr_data_d;
      tcnt      <= tcnt_d;
      pcnt      <= pcnt_d;
      poll_pend <= poll_pend_d;
      set_pend  <= set_pend_d;
      lat_sec   <= lat_sec_d;
      lat_min   <= lat_min_d;
      lat_hour  <= lat_hour_d;
      w_min     <= w_min_d;
      w_hour    <= w_hour_d;
      sh_sec    <= sh_sec_d;
      sh_min    <= sh_min_d;
      sh_vl     <= sh_vl_d;
      sec       <= sec_d;
      min       <= min_d;
      hour      <= hour_d;
      vl        <= vl_d;
      valid     <= valid_d;
      update    <= update_d;
      set_ack   <= set_ack_d;
      err       <= err_d;
    end
  end

  always_comb begin
    state_d    = state;
    seq_d      = seq;
    step_d     = step;
    cont_d     = cont;
    call_d     = call;
    wr_data_d  = wr_data;
    tcnt_d     = tcnt;
    lat_sec_d  = lat_sec;
    lat_min_d  = lat_min;
    lat_hour_d = lat_hour;
    w_min_d    = w_min;
    w_hour_d   = w_hour;
    sh_sec_d   = sh_sec;
    sh_min_d   = sh_min;
    sh_vl_d    = sh_vl;
    sec_d      = sec;
    min_d      = min;
    hour_d     = hour;
    vl_d       = vl;
    valid_d    = valid;
    update_d   = 1'b0;
    set_ack_d  = 1'b0;
    err_d      = 1'b0;
    poll_start = 1'b0;
    set_start  = 1'b0;

    expiry = (pcnt == '0);
    pcnt_d = expiry ? POLL_RELOAD : pcnt - PW'(1);

    case (state)
      S_INIT: begin
        seq_d     = Q_INIT;
        step_d    = 2'd0;
        call_d    = 8'h80;
        wr_data_d = CTRL_INIT;
        tcnt_d    = '0;
        state_d   = S_CALL;
      end
      S_IDLE: begin
        // Later write data is copied so a new request cannot corrupt this sequence.
        if (set_pend) begin
          set_start = 1'b1;
          seq_d     = Q_SET;
          step_d    = 2'd0;
          call_d    = 8'h40;
          wr_data_d = lat_sec;
          w_min_d   = lat_min;
          w_hour_d  = lat_hour;
          tcnt_d    = '0;
          state_d   = S_CALL;
        end else if (poll_pend) begin
          poll_start = 1'b1;
          seq_d      = Q_POLL;
          step_d     = 2'd0;
          call_d     = 8'h04;
          wr_data_d  = 8'h00;
          tcnt_d     = '0;
          state_d    = S_CALL;
        end
      end
      S_CALL: begin
        if (iDone) begin
          call_d    = 8'h00;
          wr_data_d = 8'h00;
          state_d   = S_GAP;
          cont_d    = (seq != Q_INIT) && (step != 2'd2);
          step_d    = step + 2'd1;
          if (seq == Q_POLL) begin
            case (step)
              2'd0: begin
                sh_sec_d = iRdData & 8'h7F;
                sh_vl_d  = iRdData[7];
              end
              2'd1: sh_min_d = iRdData & 8'h7F;
              default: begin
                sec_d    = sh_sec;
                min_d    = sh_min;
                hour_d   = hour_rd;
                vl_d     = sh_vl;
                valid_d  = 1'b1;
                update_d = !valid || (sh_sec != sec) || (sh_min != min) ||
                           (hour_rd != hour) || (sh_vl != vl);
              end
            endcase
          end
          if ((seq == Q_SET) && (step == 2'd2)) set_ack_d = 1'b1;
        end else if (tcnt == TMO_LAST) begin
          call_d    = 8'h00;
          wr_data_d = 8'h00;
          err_d     = 1'b1;
          cont_d    = 1'b0;
          sh_sec_d  = 8'h00;
          sh_min_d  = 8'h00;
          sh_vl_d   = 1'b0;
          state_d   = S_GAP;
        end else begin
          tcnt_d = tcnt + TW'(1);
        end
      end
      S_GAP: begin
        if (cont) begin
          state_d = S_CALL;
          tcnt_d  = '0;
          if (seq == Q_SET) begin
            call_d    = (step == 2'd1) ? 8'h20 : 8'h10;
            wr_data_d = (step == 2'd1) ? w_min : w_hour;
          end else begin
            call_d    = (step == 2'd1) ? 8'h02 : 8'h01;
            wr_data_d = 8'h00;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_INIT;
    endcase

    // An expiry while a poll is already pending (or just being started) is dropped.
    poll_pend_d = poll_start ? 1'b0 : (poll_pend | expiry);

    set_pend_d = set_pend;
    if (iSetReq) begin
      lat_sec_d  = iSetSec;
      lat_min_d  = iSetMin;
      lat_hour_d = iSetHour;
      set_pend_d = 1'b1;
    end else if (set_start) begin
      set_pend_d = 1'b0;
    end
  end

  assign oCall   = call;
  assign oWrData = wr_data;
  assign oSetAck = set_ack;
  assign oSec    = sec;
  assign oMin    = min;
  assign oHour   = hour;
  assign oVL     = vl;
  assign oValid  = valid;
  assign oUpdate = update;
  assign oErr    = err;

endmodule

// File: tb/tb_pcf8563_sched.sv
// Self-checking bench for pcf8563_sched: table-driven polls, randomized polls
// against a transaction-level snapshot model, and set/timeout/reset sequences.
module tb_pcf8563_sched;

  localparam int POLL = 64;
  localparam int TMO  = 8;

  logic       CLOCK = 1'b0;
  logic       RST_n = 1'b0;
  logic [7:0] oCall, oWrData, iRdData;
  logic       iDone;
  logic       iSetReq = 1'b0;
  logic [7:0] iSetSec = 8'h00, iSetMin = 8'h00, iSetHour = 8'h00;
  logic       oSetAck, oVL, oValid, oUpdate, oErr;
  logic [7:0] oSec, oMin, oHour;

  pcf8563_sched #(.POLL_CYCLES(POLL), .TIMEOUT(TMO), .CTRL_INIT(8'h00)) dut (
    .CLOCK(CLOCK), .RST_n(RST_n), .oCall(oCall), .iDone(iDone),
    .oWrData(oWrData), .iRdData(iRdData), .iSetReq(iSetReq),
    .iSetSec(iSetSec), .iSetMin(iSetMin), .iSetHour(iSetHour),
    .oSetAck(oSetAck), .oSec(oSec), .oMin(oMin), .oHour(oHour),
    .oVL(oVL), .oValid(oValid), .oUpdate(oUpdate), .oErr(oErr)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    logic [7:0] code;
    logic [7:0] data;
    int         startNeg;
    int         gap;
  } callRec_t;

  typedef struct {
    logic [7:0] rs, rm, rh;
    logic [7:0] es, em, eh;
    logic       ev;
    logic       eu;
  } vec_t;

  callRec_t   callLog[$];
  vec_t       vecs[8];

  int testCount = 0, failCount = 0;
  int negCnt = 0, callAge = 0, lastHighNeg = -100;
  int respDelay = 3;
  logic [7:0] withholdCode = 8'h00;
  logic [7:0] rdSec = 8'h00, rdMin = 8'h00, rdHour = 8'h00;
  int hourDones = 0, updCount = 0, ackCount = 0, errCount = 0;
  int widthErrs = 0, protoErrs = 0;
  int setHourDoneNeg = 0, ackNeg = 0, errNeg = 0;
  logic prevUpd = 1'b0, prevAck = 1'b0, prevErr = 1'b0;
  logic [7:0] prevCall = 8'h00;

  logic       refValid = 1'b0, refVl = 1'b0, refUpd = 1'b0;
  logic [7:0] refSec = 8'h00, refMin = 8'h00, refHour = 8'h00;

  // Control-module stand-in: acknowledges each call respDelay cycles after it appears.
  initial begin
    iDone   = 1'b0;
    iRdData = 8'h00;
    forever begin
      @(negedge CLOCK);
      negCnt++;
      iDone = 1'b0;
      if (oUpdate) updCount++;
      if (oSetAck) begin ackCount++; ackNeg = negCnt; end
      if (oErr) begin errCount++; errNeg = negCnt; end
      if ((oUpdate && prevUpd) || (oSetAck && prevAck) || (oErr && prevErr)) widthErrs++;
      if (oCall != 8'h00 && $countones(oCall) != 1) protoErrs++;
      if (oCall != 8'h00 && prevCall != 8'h00 && oCall != prevCall) protoErrs++;
      prevUpd  = oUpdate;
      prevAck  = oSetAck;
      prevErr  = oErr;
      prevCall = oCall;
      if (oCall != 8'h00) begin
        if (callAge == 0) callLog.push_back('{oCall, oWrData, negCnt, negCnt - lastHighNeg - 1});
        callAge++;
        lastHighNeg = negCnt;
        if (oCall != withholdCode && callAge == respDelay) begin
          iDone   = 1'b1;
          iRdData = (oCall == 8'h04) ? rdSec : (oCall == 8'h02) ? rdMin :
                    (oCall == 8'h01) ? rdHour : 8'h00;
          if (oCall == 8'h01) hourDones++;
          if (oCall == 8'h10) setHourDoneNeg = negCnt;
        end
      end else begin
        callAge = 0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] s, input logic [7:0] m, input logic [7:0] h, input int dly);
    rdSec     = s;
    rdMin     = m;
    rdHour    = h;
    respDelay = dly;
  endtask

  // Snapshot model: a commit publishes masked values and flags any change.
  task automatic modelPoll(input logic [7:0] s, input logic [7:0] m, input logic [7:0] h);
    logic [7:0] ns, nm, nh;
    logic       nv;
    ns = s & 8'h7F;
    nm = m & 8'h7F;
    nh = h & 8'h3F;
    nv = s[7];
    refUpd   = !refValid || ns != refSec || nm != refMin || nh != refHour || nv != refVl;
    refSec   = ns;
    refMin   = nm;
    refHour  = nh;
    refVl    = nv;
    refValid = 1'b1;
  endtask

  task automatic waitCommit(input string name, output int updDelta);
    int  h0  = hourDones;
    int  u0  = updCount;
    bit  got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge CLOCK); #1;
      if (hourDones != h0) got = 1'b1;
    end
    checkOutput($sformatf("%s_commit_seen", name), 32'(got), 32'd1);
    @(negedge CLOCK); #1;
    updDelta = updCount - u0;
  endtask

  task automatic checkSnapshot(input string name, input int updDelta);
    checkOutput($sformatf("%s_sec", name), oSec, refSec);
    checkOutput($sformatf("%s_min", name), oMin, refMin);
    checkOutput($sformatf("%s_hour", name), oHour, refHour);
    checkOutput($sformatf("%s_vl", name), oVL, refVl);
    checkOutput($sformatf("%s_upd", name), updDelta, 32'(refUpd));
    checkOutput($sformatf("%s_valid", name), oValid, 1);
  endtask

  function automatic int lastIdx(input logic [7:0] code);
    for (int i = callLog.size() - 1; i >= 0; i--)
      if (callLog[i].code == code) return i;
    return -1;
  endfunction

  initial begin
    int         ud, n, idx, target;
    bit         got;
    logic [7:0] rs, rm, rh;

    vecs[0] = '{8'hD9, 8'hB7, 8'hE3, 8'h59, 8'h37, 8'h23, 1'b1, 1'b1};
    vecs[1] = '{8'hD9, 8'hB7, 8'hE3, 8'h59, 8'h37, 8'h23, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 8'hB7, 8'hE3, 8'h00, 8'h37, 8'h23, 1'b0, 1'b1};
    vecs[3] = '{8'h00, 8'h37, 8'h23, 8'h00, 8'h37, 8'h23, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 8'h37, 8'h23, 8'h00, 8'h37, 8'h23, 1'b1, 1'b1};
    vecs[5] = '{8'h00, 8'h37, 8'h63, 8'h00, 8'h37, 8'h23, 1'b0, 1'b1};
    vecs[6] = '{8'h00, 8'hB7, 8'hA3, 8'h00, 8'h37, 8'h23, 1'b0, 1'b0};
    vecs[7] = '{8'hFF, 8'hFF, 8'hFF, 8'h7F, 8'h7F, 8'h3F, 1'b1, 1'b1};

    repeat (3) @(negedge CLOCK);
    #1;
    checkOutput("rst_call", oCall, 8'h00);
    checkOutput("rst_sec", oSec, 8'h00);
    checkOutput("rst_flags", {oVL, oValid, oUpdate, oErr, oSetAck}, 5'b0);

    applyStimulus(vecs[0].rs, vecs[0].rm, vecs[0].rh, 3);
    RST_n = 1'b1;
    @(negedge CLOCK); #1;
    checkOutput("init_call", oCall, 8'h80);
    checkOutput("init_wrdata", oWrData, 8'h00);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].rs, vecs[i].rm, vecs[i].rh, 3);
      waitCommit($sformatf("vec%0d", i), ud);
      modelPoll(vecs[i].rs, vecs[i].rm, vecs[i].rh);
      checkOutput($sformatf("vec%0d_sec", i), oSec, vecs[i].es);
      checkOutput($sformatf("vec%0d_min", i), oMin, vecs[i].em);
      checkOutput($sformatf("vec%0d_hour", i), oHour, vecs[i].eh);
      checkOutput($sformatf("vec%0d_vl", i), oVL, vecs[i].ev);
      checkOutput($sformatf("vec%0d_upd", i), ud, 32'(vecs[i].eu));
      checkOutput($sformatf("vec%0d_valid", i), oValid, 1);
    end

    checkOutput("seq0_code", callLog[0].code, 8'h80);
    checkOutput("seq0_data", callLog[0].data, 8'h00);
    checkOutput("seq1_code", callLog[1].code, 8'h04);
    checkOutput("seq2_code", callLog[2].code, 8'h02);
    checkOutput("seq2_gap", callLog[2].gap, 1);
    checkOutput("seq3_code", callLog[3].code, 8'h01);
    checkOutput("seq3_gap", callLog[3].gap, 1);

    rs = 8'h00; rm = 8'h00; rh = 8'h00;
    for (int i = 0; i < 12; i++) begin
      if (i == 0 || $urandom_range(0, 2) != 0) begin
        rs = 8'($urandom);
        rm = 8'($urandom);
        rh = 8'($urandom);
      end
      applyStimulus(rs, rm, rh, $urandom_range(1, 5));
      waitCommit($sformatf("rnd%0d", i), ud);
      modelPoll(rs, rm, rh);
      checkSnapshot($sformatf("rnd%0d", i), ud);
    end

    // Time-set request landing on the same edge as the next timer expiry.
    respDelay = 2;
    idx = lastIdx(8'h04);
    target = callLog[idx].startNeg + POLL - 2;
    for (int i = 0; i < 200 && negCnt < target; i++) begin
      @(negedge CLOCK); #1;
    end
    checkOutput("set_on_expiry", negCnt, target);
    n = callLog.size();
    iSetSec = 8'h30; iSetMin = 8'h15; iSetHour = 8'h12; iSetReq = 1'b1;
    @(negedge CLOCK); #1;
    iSetReq = 1'b0; iSetSec = 8'h00; iSetMin = 8'h00; iSetHour = 8'h00;
    waitCommit("setpoll", ud);
    modelPoll(rdSec, rdMin, rdHour);
    checkSnapshot("setpoll", ud);
    checkOutput("set_ack_count", ackCount, 1);
    checkOutput("set_ack_timing", ackNeg, setHourDoneNeg + 1);
    checkOutput("set_c0", {callLog[n].code, callLog[n].data}, 16'h4030);
    checkOutput("set_c1", {callLog[n+1].code, callLog[n+1].data}, 16'h2015);
    checkOutput("set_c1_gap", callLog[n+1].gap, 1);
    checkOutput("set_c2", {callLog[n+2].code, callLog[n+2].data}, 16'h1012);
    checkOutput("set_c2_gap", callLog[n+2].gap, 1);
    checkOutput("set_then_poll", callLog[n+3].code, 8'h04);

    // Read-min never acknowledged.
    n = callLog.size();
    withholdCode = 8'h02;
    ud = updCount;
    idx = errCount;
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge CLOCK); #1;
      if (errCount != idx) got = 1'b1;
    end
    checkOutput("tmo_err_seen", 32'(got), 32'd1);
    checkOutput("tmo_call_off", oCall, 8'h00);
    checkOutput("tmo_sec", oSec, refSec);
    checkOutput("tmo_hour", oHour, refHour);
    checkOutput("tmo_no_upd", updCount, ud);
    idx = -1;
    for (int i = n; i < callLog.size(); i++)
      if (idx < 0 && callLog[i].code == 8'h02) idx = i;
    checkOutput("tmo_found", 32'(idx >= 0), 32'd1);
    if (idx >= 0)
      checkOutput("tmo_len", 32'((errNeg - callLog[idx].startNeg) inside {TMO, TMO + 1}), 32'd1);
    withholdCode = 8'h00;
    applyStimulus(8'h45, 8'h12, 8'h09, 3);
    waitCommit("after_tmo", ud);
    modelPoll(8'h45, 8'h12, 8'h09);
    checkSnapshot("after_tmo", ud);
    if (idx >= 0) checkOutput("tmo_abandoned", callLog[idx+1].code, 8'h04);

    // Reset in the middle of read-min.
    withholdCode = 8'h02;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge CLOCK); #1;
      if (oCall == 8'h02) got = 1'b1;
    end
    checkOutput("mid_rst_reached", 32'(got), 32'd1);
    RST_n = 1'b0;
    @(negedge CLOCK); #1;
    checkOutput("mid_rst_call", {oCall, oWrData}, 16'h0000);
    checkOutput("mid_rst_snap", {oSec, oMin, oHour}, 24'h000000);
    checkOutput("mid_rst_flags", {oVL, oValid, oUpdate, oErr, oSetAck}, 5'b0);
    withholdCode = 8'h00;
    refValid = 1'b0;
    RST_n = 1'b1;
    @(negedge CLOCK); #1;
    checkOutput("reinit_call", oCall, 8'h80);
    checkOutput("reinit_valid", oValid, 0);
    applyStimulus(8'h45, 8'h12, 8'h09, 2);
    waitCommit("after_rst", ud);
    modelPoll(8'h45, 8'h12, 8'h09);
    checkSnapshot("after_rst", ud);

    checkOutput("pulse_width", widthErrs, 0);
    checkOutput("call_protocol", protoErrs, 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
